// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Used by the fetch unit and branch-target logic.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   localparam int INSTR_BYTES = 4;
   localparam int WORD_SHIFT  = 2;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target adder: pc + (word offset << 2).
// Wraps modulo 2^ADDR_WIDTH.
module branch_target_calc
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH = 64
) (
   input  logic [ADDR_WIDTH-1:0] branch_pc_in,
   input  logic [ADDR_WIDTH-1:0] branch_offset_in,
   output logic [ADDR_WIDTH-1:0] target
);

   // word offset scaled to bytes, added with natural wrap
   assign target = branch_pc_in
                 + (branch_offset_in << WORD_SHIFT);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch with branch redirect.
// Squashes in-flight fetch data when a redirect arrives.
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   PC_src_in,
   input  logic [ADDR_WIDTH-1:0]  branch_pc_in,
   input  logic [ADDR_WIDTH-1:0]  branch_offset_in,
   output logic                   imem_req_out,
   output logic [ADDR_WIDTH-1:0]  imem_addr_out,
   input  logic                   imem_ack_in,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_in,
   output logic                   instr_valid_out,
   input  logic                   instr_ready_in,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic [ADDR_WIDTH-1:0]  pc_out
);

   fetch_state_t          state;
   logic [ADDR_WIDTH-1:0] pc_reg;
   logic [ADDR_WIDTH-1:0] redirect_reg;
   logic [ADDR_WIDTH-1:0] target;
   logic                  in_fetch;
   logic                  in_wait;
   logic                  in_discard;
   logic                  capture;
   logic                  release_out;

   branch_target_calc #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_target (
      .branch_pc_in    (branch_pc_in),
      .branch_offset_in(branch_offset_in),
      .target          (target)
   );

   // state decodes and output-register events
   always_comb begin
      in_fetch    = (state == FETCH);
      in_wait     = (state == WAIT);
      in_discard  = (state == DISCARD);
      capture     = in_fetch && imem_ack_in && !PC_src_in;
      release_out = in_wait && (instr_ready_in || PC_src_in);
   end

   // request is a Moore decode, forced low during reset
   assign imem_req_out  = (in_fetch || in_discard) && !reset;
   assign imem_addr_out = pc_reg;

   // fetch control: state, pc and pending redirect target
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= FETCH;
         pc_reg       <= RESET_PC;
         redirect_reg <= '0;
      end else begin
         unique case (state)
            FETCH: begin
               if (imem_ack_in) begin
                  if (PC_src_in) begin
                     pc_reg <= target;
                  end else begin
                     pc_reg <= pc_reg
                             + ADDR_WIDTH'(INSTR_BYTES);
                     state  <= WAIT;
                  end
               end else if (PC_src_in) begin
                  redirect_reg <= target;
                  state        <= DISCARD;
               end
            end
            WAIT: begin
               if (PC_src_in) begin
                  pc_reg <= target;
                  state  <= FETCH;
               end else if (instr_ready_in) begin
                  state <= FETCH;
               end
            end
            DISCARD: begin
               if (imem_ack_in) begin
                  pc_reg <= PC_src_in ? target
                                      : redirect_reg;
                  state  <= FETCH;
               end else if (PC_src_in) begin
                  redirect_reg <= target;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   // decode-facing output register, held while stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_valid_out <= 1'b0;
         instr_out       <= '0;
         pc_out          <= '0;
      end else if (capture) begin
         instr_valid_out <= 1'b1;
         instr_out       <= imem_rdata_in;
         pc_out          <= pc_reg;
      end else if (release_out) begin
         instr_valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a transaction-level
// reference model checked every cycle.
module tb_pc_fetch_unit;

   localparam logic [63:0] RST_PC = 64'h400;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        PC_src_in = 1'b0;
   logic [63:0] branch_pc_in = '0;
   logic [63:0] branch_offset_in = '0;
   logic        imem_req_out;
   logic [63:0] imem_addr_out;
   logic        imem_ack_in = 1'b0;
   logic [31:0] imem_rdata_in;
   logic        instr_valid_out;
   logic        instr_ready_in = 1'b1;
   logic [31:0] instr_out;
   logic [63:0] pc_out;

   int total = 0;
   int bad = 0;

   pc_fetch_unit #(
      .RESET_PC   (RST_PC),
      .ADDR_WIDTH (64),
      .INSTR_WIDTH(32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .PC_src_in       (PC_src_in),
      .branch_pc_in    (branch_pc_in),
      .branch_offset_in(branch_offset_in),
      .imem_req_out    (imem_req_out),
      .imem_addr_out   (imem_addr_out),
      .imem_ack_in     (imem_ack_in),
      .imem_rdata_in   (imem_rdata_in),
      .instr_valid_out (instr_valid_out),
      .instr_ready_in  (instr_ready_in),
      .instr_out       (instr_out),
      .pc_out          (pc_out)
   );

   // memory contents: tag plus low address bits
   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {16'hC0DE, a};
   endfunction

   assign imem_rdata_in = mem_word(imem_addr_out[15:0]);

   initial forever #5 clk = ~clk;

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // reference model: a fetch is requested whenever nothing is
   // being held for decode; a squash flag marks data to throw away
   logic        m_valid = 1'b0;
   logic        m_squash = 1'b0;
   logic [63:0] m_redir = '0;
   logic [63:0] m_addr = RST_PC;
   logic [31:0] m_instr = '0;
   logic [63:0] m_pc = '0;
   logic [63:0] m_tgt;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_valid  = 1'b0;
         m_squash = 1'b0;
         m_redir  = '0;
         m_addr   = RST_PC;
         m_instr  = '0;
         m_pc     = '0;
      end else begin
         m_tgt = branch_pc_in + branch_offset_in * 64'd4;
         if (m_valid) begin
            if (PC_src_in) begin
               m_valid = 1'b0;
               m_addr  = m_tgt;
            end else if (instr_ready_in) begin
               m_valid = 1'b0;
            end
         end else if (imem_ack_in) begin
            if (m_squash) begin
               m_squash = 1'b0;
               m_addr   = PC_src_in ? m_tgt : m_redir;
            end else if (PC_src_in) begin
               m_addr = m_tgt;
            end else begin
               m_instr = imem_rdata_in;
               m_pc    = m_addr;
               m_addr  = m_addr + 64'd4;
               m_valid = 1'b1;
            end
         end else if (PC_src_in) begin
            m_squash = 1'b1;
            m_redir  = m_tgt;
         end
      end
   end

   // every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      check("req", {63'd0, imem_req_out},
            {63'd0, !m_valid && !reset});
      if (!m_valid && !reset)
         check("addr", imem_addr_out, m_addr);
      check("valid", {63'd0, instr_valid_out}, {63'd0, m_valid});
      check("instr", {32'd0, instr_out}, {32'd0, m_instr});
      check("pc_out", pc_out, m_pc);
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic redir(input logic [63:0] bpc,
                        input logic [63:0] off);
      PC_src_in        = 1'b1;
      branch_pc_in     = bpc;
      branch_offset_in = off;
   endtask

   initial begin
      repeat (2) cyc();
      check("rst_req", {63'd0, imem_req_out}, 64'd0);
      check("rst_valid", {63'd0, instr_valid_out}, 64'd0);
      check("rst_instr", {32'd0, instr_out}, 64'd0);
      check("rst_pc", pc_out, 64'd0);

      // zero-wait memory, decode always ready
      imem_ack_in = 1'b1;
      reset = 1'b0;
      #1;
      check("first_req", {63'd0, imem_req_out}, 64'd1);
      check("first_addr", imem_addr_out, 64'h400);
      cyc();
      check("zw_valid0", {63'd0, instr_valid_out}, 64'd1);
      check("zw_pc0", pc_out, 64'h400);
      check("zw_instr0", {32'd0, instr_out}, 64'hC0DE0400);
      check("model_pin0", m_pc, 64'h400);
      cyc();
      check("zw_gap", {63'd0, instr_valid_out}, 64'd0);
      check("zw_addr1", imem_addr_out, 64'h404);
      cyc();
      check("zw_pc1", pc_out, 64'h404);
      cyc();
      check("zw_addr2", imem_addr_out, 64'h408);
      cyc();
      check("zw_pc2", pc_out, 64'h408);
      check("zw_instr2", {32'd0, instr_out}, 64'hC0DE0408);
      cyc();

      // ack held off for three cycles
      imem_ack_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("slow_addr", imem_addr_out, 64'h40C);
         check("slow_novalid", {63'd0, instr_valid_out}, 64'd0);
      end
      imem_ack_in = 1'b1;
      cyc();
      check("slow_valid", {63'd0, instr_valid_out}, 64'd1);
      check("slow_pc", pc_out, 64'h40C);

      // decode stall; stray acks must be ignored
      instr_ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("stall_pc", pc_out, 64'h40C);
         check("stall_instr", {32'd0, instr_out}, 64'hC0DE040C);
         check("stall_req", {63'd0, imem_req_out}, 64'd0);
      end
      instr_ready_in = 1'b1;
      imem_ack_in = 1'b0;
      cyc();
      check("unstall_addr", imem_addr_out, 64'h410);
      check("unstall_req", {63'd0, imem_req_out}, 64'd1);

      // redirect while waiting on ack: squash then 0xFF0
      redir(64'h1000, 64'hFFFF_FFFF_FFFF_FFFC);
      cyc();
      PC_src_in = 1'b0;
      check("disc_addr", imem_addr_out, 64'h410);
      cyc();
      imem_ack_in = 1'b1;
      cyc();
      imem_ack_in = 1'b0;
      check("disc_novalid", {63'd0, instr_valid_out}, 64'd0);
      check("disc_target", imem_addr_out, 64'hFF0);
      check("model_pin1", m_addr, 64'hFF0);

      // two redirects in discard: latest wins
      redir(64'h2000, 64'd0);
      cyc();
      redir(64'h3000, 64'd0);
      cyc();
      PC_src_in = 1'b0;
      imem_ack_in = 1'b1;
      cyc();
      check("latest_wins", imem_addr_out, 64'h3000);

      // redirect coincident with ack in fetch
      redir(64'h5000, 64'd3);
      cyc();
      check("coinc_novalid", {63'd0, instr_valid_out}, 64'd0);
      check("coinc_addr", imem_addr_out, 64'h500C);

      // target wraps modulo 2^64
      redir(64'hFFFF_FFFF_FFFF_FFF8, 64'd4);
      cyc();
      check("wrap_addr", imem_addr_out, 64'h8);
      PC_src_in = 1'b0;
      cyc();
      check("wrap_pc", pc_out, 64'h8);

      // redirect in wait takes priority over ready
      redir(64'h100, 64'd1);
      imem_ack_in = 1'b0;
      cyc();
      check("wait_redir", imem_addr_out, 64'h104);
      check("wait_novalid", {63'd0, instr_valid_out}, 64'd0);

      // redirect coincident with ack in discard
      redir(64'h700, 64'd0);
      cyc();
      redir(64'h800, 64'd0);
      imem_ack_in = 1'b1;
      cyc();
      check("disc_coinc", imem_addr_out, 64'h800);

      // async reset in the middle of discard
      redir(64'h900, 64'd0);
      imem_ack_in = 1'b0;
      cyc();
      PC_src_in = 1'b0;
      reset = 1'b1;
      #1;
      check("arst_req", {63'd0, imem_req_out}, 64'd0);
      check("arst_valid", {63'd0, instr_valid_out}, 64'd0);
      check("arst_instr", {32'd0, instr_out}, 64'd0);
      check("arst_pc", pc_out, 64'd0);
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      check("restart_addr", imem_addr_out, 64'h400);
      imem_ack_in = 1'b1;
      cyc();
      check("restart_pc", pc_out, 64'h400);
      cyc();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
